dmem_port_arbiter: RTL
======================

// Module: dmem_port_arbiter
// PURPOSE
//  Arbitrates the single shared data-memory port between the CPU load/store path and a secondary
//  requester (the RAS spill/fill engine). CPU has priority; a starvation counter guarantees the
//  secondary a slot within STARVE_MAX cycles by stalling the CPU via cpu_hold. Sits between the
//  core bus and the shared memory interface; replaces the idle-cycle-only steal scheme.
// PARAMETERS
//  STARVE_MAX   8        cycles a pending sec_req may lose before it is force-granted (1..255)
//  BASE_OFFSET  32'h2000 subtracted from the winning address before driving mem_addr
// PORTS
//  clk          in   1   system clock
//  Rst          in   1   synchronous active-high reset
//  cpu_rd       in   1   CPU load request
//  cpu_wr       in   1   CPU store request
//  cpu_mmio     in   1   CPU address decodes to MMIO; request is not forwarded to memory
//  cpu_addr     in   32  CPU byte address
//  cpu_din      in   32  CPU store data
//  cpu_wen      in   4   CPU byte-lane write enables
//  cpu_strctrl  in   3   CPU store control
//  cpu_hold     out  1   CPU must stall and hold its request stable this cycle
//  cpu_dout     out  32  load data (mem_dout pass-through)
//  sec_req      in   1   secondary request; held high with stable fields until sec_gnt
//  sec_wr       in   1   1 = write, 0 = read
//  sec_addr     in   32  secondary byte address (word aligned)
//  sec_din      in   32  secondary write data
//  sec_gnt      out  1   request accepted this cycle (combinational)
//  sec_dout     out  32  secondary read data, valid with sec_dvalid
//  sec_dvalid   out  1   one-cycle pulse, the cycle after a granted secondary read
//  mem_en       out  1   memory access enable
//  mem_addr     out  32  owner address minus BASE_OFFSET
//  mem_din      out  32  owner write data
//  mem_wen      out  4   byte-lane write enables
//  mem_strctrl  out  3   store control
//  mem_dout     in   32  memory read data, 1-cycle latency
//  stat_hold    out  16  CPU-hold cycle count (see CONFIGURATION)
//  stat_sec     out  16  secondary grant count (see CONFIGURATION)
// BEHAVIOUR
//  - cpu_act = (cpu_rd|cpu_wr) & ~cpu_mmio. starve = (cnt == STARVE_MAX).
//  - Owner per cycle (combinational): SEC if sec_req & (~cpu_act | starve); else CPU if cpu_act;
//    else NONE. sec_gnt = (owner==SEC). cpu_hold = cpu_act & (owner==SEC).
//  - CPU owner: mem_* = cpu_* (wen/strctrl as given), mem_en=1. SEC owner: mem_en=1,
//    mem_wen = sec_wr ? 4'b1111 : 4'b0000, mem_strctrl = sec_wr ? 3'b100 : 3'b000.
//    NONE: mem_en=0, mem_wen=0, mem_strctrl=0, addr/din = CPU fields.
//  - cnt (8b): cleared on Rst, on sec_gnt, or when ~sec_req; else if sec_req & ~sec_gnt,
//    increments, saturating at STARVE_MAX. Forced grant clears cnt so CPU wins next cycle;
//    max CPU stall from one sec stream = 1 cycle per STARVE_MAX+1.
//  - rd_pend flop <= sec_gnt & ~sec_wr; sec_dvalid = rd_pend; sec_dout = mem_dout.
//    cpu_dout = mem_dout unconditionally; CPU read data timing unchanged (1 cycle).
//  - Reset values: cnt=0, rd_pend=0 (sec_dvalid=0), stats=0. Reset mid-operation drops any
//    in-flight secondary read: no sec_dvalid the cycle after Rst.
//  - Rst asserted: outputs still follow combinational owner rules (arbitration is stateless
//    apart from cnt); requesters must not rely on accesses issued during Rst.
//  - cpu_mmio accesses never stall and never block the secondary.
// CONFIGURATION
//  DMEM_ARB_STATS_EN defined: stat_hold increments on every cpu_hold cycle, stat_sec on every
//  sec_gnt; both 16b saturating at 16'hFFFF, cleared by Rst.
//  Not defined: counters not built; stat_hold and stat_sec tied to 16'h0.
// TESTING
//  1 CPU read addr 0x2010 alone -> mem_en=1, mem_addr=0x10, wen=0, no hold; cpu_dout next cycle.
//  2 sec write addr 0x3000 data 0xDEADBEEF, CPU idle -> same-cycle sec_gnt, mem_addr=0x1000,
//    wen=4'hF, strctrl=3'b100; no sec_dvalid.
//  3 CPU busy every cycle + sec read pending, STARVE_MAX=8 -> CPU owns 8 cycles, 9th cycle
//    sec_gnt=1 & cpu_hold=1, next cycle sec_dvalid=1 and CPU owns again; repeats every 9 cycles.
//  4 CPU MMIO access (cpu_mmio=1) with sec_req -> sec_gnt=1, cpu_hold=0, mem_addr from sec.
//  5 sec read granted, Rst asserted next cycle -> sec_dvalid stays 0, cnt=0 after Rst.
//  6 DMEM_ARB_STATS_EN: scenario 3 for 27 cycles -> stat_hold=3, stat_sec=3; undefined -> both 0.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: bundles the CPU load/store path, the secondary
// requester, the shared memory port and the statistics outputs.
// slave  = arbiter side, master = requesters + memory side.
interface dmem_port_arbiter_if;
   logic        cpu_rd;
   logic        cpu_wr;
   logic        cpu_mmio;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_din;
   logic [3:0]  cpu_wen;
   logic [2:0]  cpu_strctrl;
   logic        cpu_hold;
   logic [31:0] cpu_dout;
   logic        sec_req;
   logic        sec_wr;
   logic [31:0] sec_addr;
   logic [31:0] sec_din;
   logic        sec_gnt;
   logic [31:0] sec_dout;
   logic        sec_dvalid;
   logic        mem_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic [3:0]  mem_wen;
   logic [2:0]  mem_strctrl;
   logic [31:0] mem_dout;
   logic [15:0] stat_hold;
   logic [15:0] stat_sec;

   modport slave (
      input  cpu_rd, cpu_wr, cpu_mmio, cpu_addr, cpu_din, cpu_wen, cpu_strctrl,
      input  sec_req, sec_wr, sec_addr, sec_din, mem_dout,
      output cpu_hold, cpu_dout, sec_gnt, sec_dout, sec_dvalid,
      output mem_en, mem_addr, mem_din, mem_wen, mem_strctrl, stat_hold, stat_sec
   );

   modport master (
      output cpu_rd, cpu_wr, cpu_mmio, cpu_addr, cpu_din, cpu_wen, cpu_strctrl,
      output sec_req, sec_wr, sec_addr, sec_din, mem_dout,
      input  cpu_hold, cpu_dout, sec_gnt, sec_dout, sec_dvalid,
      input  mem_en, mem_addr, mem_din, mem_wen, mem_strctrl, stat_hold, stat_sec
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory port between the CPU and the
// RAS spill/fill engine. CPU has priority; a starvation counter forces a
// secondary grant (stalling the CPU) after STARVE_MAX lost cycles.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_port_arbiter #(
   parameter int unsigned STARVE_MAX  = 8,
   parameter logic [31:0] BASE_OFFSET = 32'h2000
) (
   input logic                 clk,
   input logic                 Rst,
   dmem_port_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_SEC  = 2'd2
   } owner_e;

   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

   owner_e      owner_s;
   logic        cpu_act_s;
   logic        starve_s;
   logic        sec_gnt_s;
   logic        cpu_hold_s;
   logic [7:0]  cnt_q;
   logic [7:0]  cnt_d;
   logic        rd_pend_q;
   logic        rd_pend_d;
   logic [31:0] sel_addr_s;
   logic [31:0] sel_din_s;
   logic [3:0]  sel_wen_s;
   logic [2:0]  sel_strctrl_s;
   logic        sel_en_s;

   // Pick the owner of the memory port for this cycle.
   always_comb begin
      cpu_act_s = (bus.cpu_rd | bus.cpu_wr) & ~bus.cpu_mmio;
      starve_s  = (cnt_q == STARVE_LIM);
      if (bus.sec_req && (!cpu_act_s || starve_s)) begin
         owner_s = OWN_SEC;
      end else if (cpu_act_s) begin
         owner_s = OWN_CPU;
      end else begin
         owner_s = OWN_NONE;
      end
      sec_gnt_s  = (owner_s == OWN_SEC);
      cpu_hold_s = cpu_act_s & sec_gnt_s;
   end

   // Steer the owner's fields onto the memory port; idle leaves CPU fields on addr/din.
   always_comb begin
      sel_en_s      = 1'b0;
      sel_addr_s    = bus.cpu_addr;
      sel_din_s     = bus.cpu_din;
      sel_wen_s     = 4'b0000;
      sel_strctrl_s = 3'b000;
      case (owner_s)
         OWN_CPU: begin
            sel_en_s      = 1'b1;
            sel_wen_s     = bus.cpu_wen;
            sel_strctrl_s = bus.cpu_strctrl;
         end
         OWN_SEC: begin
            sel_en_s      = 1'b1;
            sel_addr_s    = bus.sec_addr;
            sel_din_s     = bus.sec_din;
            sel_wen_s     = bus.sec_wr ? 4'b1111 : 4'b0000;
            sel_strctrl_s = bus.sec_wr ? 3'b100 : 3'b000;
         end
         default: begin
            sel_en_s = 1'b0;
         end
      endcase
   end

   // Next-state for the starvation counter and the pending secondary read.
   always_comb begin
      if (!bus.sec_req || sec_gnt_s) begin
         cnt_d = 8'd0;
      end else if (cnt_q != STARVE_LIM) begin
         cnt_d = cnt_q + 8'd1;
      end else begin
         cnt_d = cnt_q;
      end
      rd_pend_d = sec_gnt_s & ~bus.sec_wr;
   end

   // Arbitration state registers.
   always_ff @(posedge clk) begin
      if (Rst) begin
         cnt_q     <= 8'd0;
         rd_pend_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         rd_pend_q <= rd_pend_d;
      end
   end

   assign bus.mem_en      = sel_en_s;
   assign bus.mem_addr    = sel_addr_s - BASE_OFFSET;
   assign bus.mem_din     = sel_din_s;
   assign bus.mem_wen     = sel_wen_s;
   assign bus.mem_strctrl = sel_strctrl_s;
   assign bus.sec_gnt     = sec_gnt_s;
   assign bus.cpu_hold    = cpu_hold_s;
   assign bus.cpu_dout    = bus.mem_dout;
   assign bus.sec_dout    = bus.mem_dout;
   // A read in flight when Rst arrives is dropped rather than delivered.
   assign bus.sec_dvalid  = rd_pend_q & ~Rst;

`ifdef DMEM_ARB_STATS_EN
   logic [15:0] stat_hold_q;
   logic [15:0] stat_hold_d;
   logic [15:0] stat_sec_q;
   logic [15:0] stat_sec_d;

   // Saturating hold/grant event counters.
   always_comb begin
      stat_hold_d = stat_hold_q;
      stat_sec_d  = stat_sec_q;
      if (cpu_hold_s && (stat_hold_q != 16'hFFFF)) begin
         stat_hold_d = stat_hold_q + 16'd1;
      end else begin
         stat_hold_d = stat_hold_q;
      end
      if (sec_gnt_s && (stat_sec_q != 16'hFFFF)) begin
         stat_sec_d = stat_sec_q + 16'd1;
      end else begin
         stat_sec_d = stat_sec_q;
      end
   end

   // Statistics registers.
   always_ff @(posedge clk) begin
      if (Rst) begin
         stat_hold_q <= 16'd0;
         stat_sec_q  <= 16'd0;
      end else begin
         stat_hold_q <= stat_hold_d;
         stat_sec_q  <= stat_sec_d;
      end
   end

   assign bus.stat_hold = stat_hold_q;
   assign bus.stat_sec  = stat_sec_q;
`else
   assign bus.stat_hold = 16'h0;
   assign bus.stat_sec  = 16'h0;
`endif
endmodule
